// File: rtl/rmii_receiver.sv
// RMII receive deserializer: gathers LSB-first dibits qualified by crs_dv into
// DATA_W-bit words and strobes each clean word out with a one-cycle done.
// Words that saw rx_er on any of their dibits are silently dropped.
module rmii_receiver #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,    // synchronous, active-high despite the name
    input  logic              rx_er,
    input  logic [1:0]        rx_d,
    input  logic              crs_dv,
    output logic [DATA_W-1:0] data_o,
    output logic              done
);

    localparam int NDIB = DATA_W / 2;
    localparam int CW   = (NDIB > 1) ? $clog2(NDIB) : 1;
    localparam logic [CW-1:0] LAST = CW'(NDIB - 1);

    logic [CW-1:0]     cnt;
    logic [DATA_W-1:0] shreg;
    logic              err;
    logic [DATA_W-1:0] word_nxt;
    logic              last_dib;
    logic              word_bad;

    // Word as it stands once the current dibit is dropped into its slot; on the
    // last dibit this is the complete word, so the output can load it directly.
    always_comb begin
        word_nxt                       = shreg;
        word_nxt[2*int'(cnt) +: 2]     = rx_d;
        last_dib                       = crs_dv && (cnt == LAST);
        word_bad                       = err || rx_er;
    end

    // Dibit counter, shift register and per-word error flag. Dropping crs_dv
    // discards any partial word so the next dibit realigns to bits [1:0].
    always_ff @(posedge clk) begin
        if (rst_n) begin
            cnt   <= '0;
            shreg <= '0;
            err   <= 1'b0;
        end else if (!crs_dv) begin
            cnt   <= '0;
            shreg <= '0;
            err   <= 1'b0;
        end else if (last_dib) begin
            cnt   <= '0;
            shreg <= '0;
            err   <= 1'b0;
        end else begin
            cnt   <= cnt + CW'(1);
            shreg <= word_nxt;
            err   <= word_bad;
        end
    end

    // Output register and strobe: only clean completed words reach data_o.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            data_o <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (last_dib && !word_bad) begin
                data_o <= word_nxt;
                done   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rmii_receiver.sv
// Directed bench for rmii_receiver: an integer-arithmetic model of the byte
// assembly rules is checked against the DUT every cycle, and literal
// expectations at key points pin the model itself.
module tb_rmii_receiver;

    logic       clk;
    logic       rst_n;
    logic       rx_er;
    logic [1:0] rx_d;
    logic       crs_dv;
    logic [7:0] data_o;
    logic       done;

    int tests = 0;
    int fails = 0;
    bit chk_en = 0;

    rmii_receiver #(.DATA_W(8)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .rx_er  (rx_er),
        .rx_d   (rx_d),
        .crs_dv (crs_dv),
        .data_o (data_o),
        .done   (done)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Behavioural model: collect accepted dibits as an integer, weight each by
    // 4^position, publish the byte when four arrive and none carried rx_er.
    int         m_n   = 0;
    int         m_acc = 0;
    bit         m_err = 0;
    logic [7:0] exp_data = 8'h00;
    logic       exp_done = 1'b0;

    always @(posedge clk) begin
        if (rst_n === 1'b1) begin
            m_n = 0; m_acc = 0; m_err = 0;
            exp_data = 8'h00; exp_done = 1'b0;
        end else begin
            exp_done = 1'b0;
            if (crs_dv !== 1'b1) begin
                m_n = 0; m_acc = 0; m_err = 0;
            end else begin
                m_acc = m_acc + (int'(rx_d) << (2 * m_n));
                if (rx_er === 1'b1) m_err = 1;
                m_n = m_n + 1;
                if (m_n == 4) begin
                    if (!m_err) begin
                        exp_data = m_acc[7:0];
                        exp_done = 1'b1;
                    end
                    m_n = 0; m_acc = 0; m_err = 0;
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            tests++;
            if (done !== exp_done || data_o !== exp_data) begin
                fails++;
                $display("FAIL model_cmp t=%0t: got done=%b data=%h, want done=%b data=%h",
                         $time, done, data_o, exp_done, exp_data);
            end
        end
    end

    task automatic drv(input logic r, input logic dv, input logic er, input logic [1:0] d);
        @(negedge clk);
        rst_n  = r;
        crs_dv = dv;
        rx_er  = er;
        rx_d   = d;
    endtask

    // Literal check of the outputs produced by the edge that sampled the last drv.
    task automatic lit(input string name, input logic e_done, input logic [7:0] e_data);
        @(posedge clk);
        #1;
        tests++;
        if (done !== e_done || data_o !== e_data) begin
            fails++;
            $display("FAIL %s: got done=%b data=%h, want done=%b data=%h",
                     name, done, data_o, e_done, e_data);
        end
    endtask

    task automatic send4(input logic [1:0] d0, input logic [1:0] d1,
                         input logic [1:0] d2, input logic [1:0] d3);
        drv(0, 1, 0, d0);
        drv(0, 1, 0, d1);
        drv(0, 1, 0, d2);
        drv(0, 1, 0, d3);
    endtask

    initial begin
        rst_n = 1'b1; crs_dv = 1'b0; rx_er = 1'b0; rx_d = 2'b00;
        drv(1, 0, 0, 2'b00);
        drv(1, 1, 1, 2'b11);
        lit("reset", 1'b0, 8'h00);
        chk_en = 1;

        drv(0, 0, 0, 2'b00);
        lit("idle_after_reset", 1'b0, 8'h00);

        // Continuous 0x55 stream: done on the cycle after each 4th dibit.
        drv(0, 1, 0, 2'b01); lit("s55_d1", 1'b0, 8'h00);
        drv(0, 1, 0, 2'b01); lit("s55_d2", 1'b0, 8'h00);
        drv(0, 1, 0, 2'b01); lit("s55_d3", 1'b0, 8'h00);
        drv(0, 1, 0, 2'b01); lit("s55_byte1", 1'b1, 8'h55);
        drv(0, 1, 0, 2'b01); lit("s55_gap", 1'b0, 8'h55);
        drv(0, 1, 0, 2'b01);
        drv(0, 1, 0, 2'b01);
        drv(0, 1, 0, 2'b01); lit("s55_byte2", 1'b1, 8'h55);

        // Switch to 10 at a byte boundary.
        send4(2'b10, 2'b10, 2'b10, 2'b10);
        lit("sAA", 1'b1, 8'hAA);
        drv(0, 0, 0, 2'b11);
        lit("sAA_hold", 1'b0, 8'hAA);

        // Mixed patterns, back to back.
        send4(2'b01, 2'b01, 2'b01, 2'b11);
        lit("sfd_D5", 1'b1, 8'hD5);
        send4(2'b10, 2'b01, 2'b11, 2'b00);
        lit("mix_36", 1'b0 | 1'b1, 8'h36);

        // Fragment of two dibits cut by crs_dv=0, then a clean 0xFF.
        drv(0, 1, 0, 2'b10);
        drv(0, 1, 0, 2'b10);
        drv(0, 0, 1, 2'b01); lit("frag_drop", 1'b0, 8'h36);
        drv(0, 1, 0, 2'b11);
        drv(0, 1, 0, 2'b11);
        drv(0, 1, 0, 2'b11); lit("ff_pre", 1'b0, 8'h36);
        drv(0, 1, 0, 2'b11); lit("ff_byte", 1'b1, 8'hFF);

        // rx_er on the 2nd dibit suppresses that byte; next clean byte shows.
        drv(0, 1, 0, 2'b10);
        drv(0, 1, 1, 2'b10);
        drv(0, 1, 0, 2'b10);
        drv(0, 1, 0, 2'b10); lit("err_drop", 1'b0, 8'hFF);
        send4(2'b10, 2'b10, 2'b10, 2'b10);
        lit("err_recover", 1'b1, 8'hAA);

        // rx_er on the final dibit also drops the byte.
        drv(0, 1, 0, 2'b01);
        drv(0, 1, 0, 2'b01);
        drv(0, 1, 0, 2'b01);
        drv(0, 1, 1, 2'b01); lit("err_last_dib", 1'b0, 8'hAA);

        // Reset mid-byte discards the partial byte.
        drv(0, 1, 0, 2'b11);
        drv(0, 1, 0, 2'b11);
        drv(0, 1, 0, 2'b11);
        drv(1, 1, 0, 2'b11); lit("rst_mid", 1'b0, 8'h00);
        send4(2'b01, 2'b01, 2'b01, 2'b01);
        lit("post_rst_55", 1'b1, 8'h55);

        drv(0, 0, 0, 2'b00);
        drv(0, 0, 0, 2'b00);
        @(negedge clk);
        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
